program_loader: RTL and testbench

- Upstream neighbour of the processor core: owns the 256x8 program RAM that the core fetches from, replacing the fixed instruction ROM.
- Accepts a length-prefixed byte stream over a valid/ready handshake and writes it into RAM from address 0.
- Holds the core in reset while clearing or loading, then releases it so the core starts at pc 0.
- Serves combinational instruction reads addressed by the core's pc.

---
 rtl/loader_pkg.sv | 18 +
 rtl/prog_ram.sv | 27 ++
 rtl/program_loader.sv | 132 +++++++++++++
 tb/tb_program_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader and its RAM.
// State encoding, default widths and the zero-length convention.
package loader_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // A length byte of 0x00 requests a full-depth program load.
    localparam bit LEN_ZERO_MEANS_MAX = 1'b1;

    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        WAIT_LEN = 2'd1,
        LOAD     = 2'd2,
        RUN      = 2'd3
    } state_t;

endpackage

// File: rtl/prog_ram.sv
// Program storage: synchronous write port, asynchronous read port.
// Contents are not reset; the loader clears them with a sweep.
module prog_ram
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into program RAM and holds
// the core in reset until the program is complete.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [DATA_W-1:0] instruction,
    output logic              cpu_reset,
    output logic              loaded,
    output logic [ADDR_W-1:0] wr_ptr
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
    logic              r_cpu_reset;
    logic              r_loaded;

    state_t            w_state_nx;
    logic [ADDR_W-1:0] w_ptr_nx;
    logic [LEN_W-1:0]  w_len_nx;
    logic [LEN_W-1:0]  w_cnt_nx;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic              w_ready;
    logic              w_accept;
    logic [LEN_W-1:0]  w_cnt_inc;

    assign w_ready   = (r_state == WAIT_LEN) || (r_state == LOAD);
    assign w_accept  = in_valid && w_ready;
    assign w_cnt_inc = r_count + LEN_W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_wr_ptr;
        w_len_nx   = r_len;
        w_cnt_nx   = r_count;
        w_we       = 1'b0;
        w_wdata    = '0;
        // reload wins over any byte presented in the same cycle
        if (reload) begin
            w_state_nx = CLEAR;
            w_ptr_nx   = '0;
            w_cnt_nx   = '0;
        end else begin
            unique case (r_state)
                CLEAR: begin
                    w_we     = 1'b1;
                    w_ptr_nx = r_wr_ptr + ADDR_W'(1);
                    if (r_wr_ptr == PTR_LAST) begin
                        w_state_nx = WAIT_LEN;
                    end
                end
                WAIT_LEN: begin
                    if (w_accept) begin
                        if (LEN_ZERO_MEANS_MAX && in_data == '0) begin
                            w_len_nx = LEN_MAX;
                        end else begin
                            w_len_nx = LEN_W'(in_data);
                        end
                        w_ptr_nx   = '0;
                        w_cnt_nx   = '0;
                        w_state_nx = LOAD;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        w_we     = 1'b1;
                        w_wdata  = in_data;
                        w_ptr_nx = r_wr_ptr + ADDR_W'(1);
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            w_state_nx = RUN;
                        end
                    end
                end
                RUN: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_wr_ptr    <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_cpu_reset <= 1'b1;
            r_loaded    <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_wr_ptr    <= w_ptr_nx;
            r_len       <= w_len_nx;
            r_count     <= w_cnt_nx;
            r_cpu_reset <= (w_state_nx != RUN);
            r_loaded    <= (w_state_nx == RUN);
        end
    end

    prog_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (w_we),
        .waddr(r_wr_ptr),
        .wdata(w_wdata),
        .raddr(pc_addr),
        .rdata(instruction)
    );

    assign in_ready  = w_ready;
    assign cpu_reset = r_cpu_reset;
    assign loaded    = r_loaded;
    assign wr_ptr    = r_wr_ptr;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a RAM-content scoreboard.
module tb_program_loader;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       reload;
    logic [7:0] pc_addr;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic       loaded;
    logic [7:0] wr_ptr;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } sb_t;

    sb_t        sb[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] mptr;
    int         ncyc;

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reload     (reload),
        .pc_addr    (pc_addr),
        .instruction(instruction),
        .cpu_reset  (cpu_reset),
        .loaded     (loaded),
        .wr_ptr     (wr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit is_len);
        in_data  = d;
        in_valid = 1'b1;
        chk("ready_before_send", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
        if (is_len) begin
            mptr = 8'd0;
        end else begin
            sb.push_back('{addr: mptr, data: d});
            mptr = mptr + 8'd1;
        end
    endtask

    task automatic drain(input string tag);
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            pc_addr = e.addr;
            #1;
            chk(tag, {e.addr, instruction}, {e.addr, e.data});
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        chk("wait_ready_timeout", 16'(in_ready), 16'd1);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_cpu_reset", 16'(cpu_reset), 16'd1);
        chk("reload_loaded", 16'(loaded), 16'd0);
        chk("reload_wr_ptr", 16'(wr_ptr), 16'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        reload   = 1'b0;
        pc_addr  = 8'h00;
        mptr     = 8'h00;
        #1;
        chk("rst_cpu_reset", 16'(cpu_reset), 16'd1);
        chk("rst_loaded", 16'(loaded), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        chk("rst_wr_ptr", 16'(wr_ptr), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Initial sweep: in_ready rises after exactly 256 edges
        for (int i = 1; i <= 256; i++) begin
            tick();
            chk("sweep_ready", 16'(in_ready), 16'(i == 256));
            chk("sweep_flags", {8'(cpu_reset), 8'(loaded)}, 16'h0100);
        end
        sb.push_back('{addr: 8'h00, data: 8'h00});
        sb.push_back('{addr: 8'h7F, data: 8'h00});
        sb.push_back('{addr: 8'hFF, data: 8'h00});
        drain("sweep_zero");

        // Three-byte program, valid every cycle
        send(8'h03, 1'b1);
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b0);
        chk("load3_not_yet", {8'(cpu_reset), 8'(loaded)}, 16'h0100);
        send(8'hC3, 1'b0);
        chk("load3_run", {8'(cpu_reset), 8'(loaded)}, 16'h0001);
        chk("load3_ready_low", 16'(in_ready), 16'd0);
        sb.push_back('{addr: 8'h03, data: 8'h00});
        drain("load3_ram");

        // Full-depth load via length 0x00
        do_reload();
        wait_ready(ncyc);
        chk("reload_sweep_len", 16'(ncyc), 16'd256);
        send(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                chk("full_not_yet", 16'(loaded), 16'd0);
            end
            send(8'(i), 1'b0);
        end
        chk("full_run", {8'(cpu_reset), 8'(loaded)}, 16'h0001);
        chk("full_wr_ptr_wrap", 16'(wr_ptr), 16'd0);
        drain("full_ram");

        // Length 4 with random gaps and junk data while idle
        do_reload();
        wait_ready(ncyc);
        send(8'h04, 1'b1);
        for (int i = 0; i < 4; i++) begin
            automatic int gap = $urandom_range(3, 1);
            for (int g = 0; g < gap; g++) begin
                in_data = 8'hEE;
                tick();
                chk("gap_wr_ptr", 16'(wr_ptr), 16'(mptr));
            end
            send(8'h10 + 8'(i) * 8'h11, 1'b0);
        end
        chk("gap_run", 16'(loaded), 16'd1);
        sb.push_back('{addr: 8'h04, data: 8'h00});
        sb.push_back('{addr: 8'h05, data: 8'h00});
        drain("gap_ram");

        // Reload collides with a valid byte in LOAD
        do_reload();
        wait_ready(ncyc);
        send(8'h05, 1'b1);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        sb.delete();
        in_data  = 8'h55;
        in_valid = 1'b1;
        reload   = 1'b1;
        tick();
        in_valid = 1'b0;
        reload   = 1'b0;
        chk("collide_ready", 16'(in_ready), 16'd0);
        chk("collide_flags", {8'(cpu_reset), 8'(loaded)}, 16'h0100);
        chk("collide_wr_ptr", 16'(wr_ptr), 16'd0);
        pc_addr = 8'h02;
        #1;
        chk("collide_dropped", 16'(instruction), 16'h0000);
        wait_ready(ncyc);
        chk("collide_sweep_len", 16'(ncyc), 16'd256);
        for (int a = 0; a < 256; a++) begin
            sb.push_back('{addr: 8'(a), data: 8'h00});
        end
        drain("collide_cleared");

        // Asynchronous reset while running
        send(8'h01, 1'b1);
        send(8'h9A, 1'b0);
        chk("async_pre_run", 16'(loaded), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_cpu_reset", 16'(cpu_reset), 16'd1);
        chk("async_loaded", 16'(loaded), 16'd0);
        chk("async_in_ready", 16'(in_ready), 16'd0);
        chk("async_wr_ptr", 16'(wr_ptr), 16'd0);
        #2;
        reset = 1'b0;
        tick();
        chk("async_sweep_restart", 16'(wr_ptr), 16'd1);
        sb.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
